// File: rtl/rgb_sram_packer_if.sv
// Pixel-in / SRAM-write-out bundle for the RGB packer.
interface rgb_sram_packer_if;
    logic        Pix_valid;
    logic [7:0]  Pix_R;
    logic [7:0]  Pix_G;
    logic [7:0]  Pix_B;
    logic        Pix_ready;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    // Upstream pixel source and SRAM-side observer
    modport master (
        output Pix_valid, Pix_R, Pix_G, Pix_B,
        input  Pix_ready, SRAM_address, SRAM_write_data, SRAM_we_n
    );

    // Packer side
    modport slave (
        input  Pix_valid, Pix_R, Pix_G, Pix_B,
        output Pix_ready, SRAM_address, SRAM_write_data, SRAM_we_n
    );
endinterface

// File: rtl/rgb_sram_packer.sv
// Packs a stream of 24-bit RGB pixels, two pixels at a time, into three
// 16-bit SRAM words written at consecutive addresses starting at RGB_BASE.
module rgb_sram_packer #(
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter int unsigned NUM_PIXELS = 76800
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    rgb_sram_packer_if.slave    bus,
    output logic                Busy,
    output logic                Done
);

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 17;
    // Counter value seen in the S_W2 cycle of the final pixel pair
    localparam logic [CNT_W-1:0] LAST_PAIR_CNT = CNT_W'(NUM_PIXELS - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P0,
        S_P1,
        S_W2,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   pix_cnt;
    logic [ADDR_W-1:0]  wr_addr;
    logic [7:0]         b0_hold;
    logic [7:0]         g1_hold;
    logic [7:0]         b1_hold;

    logic               start_frame_c;
    logic               take_p0_c;
    logic               take_p1_c;
    logic               cnt_inc_c;
    logic               wr_c;
    logic [DATA_W-1:0]  wdata_c;

    // Next-state and per-cycle word selection
    always_comb begin
        state_nxt     = state;
        start_frame_c = 1'b0;
        take_p0_c     = 1'b0;
        take_p1_c     = 1'b0;
        cnt_inc_c     = 1'b0;
        wr_c          = 1'b0;
        wdata_c       = '0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    start_frame_c = 1'b1;
                    state_nxt     = S_P0;
                end
            end
            S_P0: begin
                if (bus.Pix_valid) begin
                    take_p0_c = 1'b1;
                    wr_c      = 1'b1;
                    wdata_c   = {bus.Pix_R, bus.Pix_G};
                    state_nxt = S_P1;
                end
            end
            S_P1: begin
                if (bus.Pix_valid) begin
                    take_p1_c = 1'b1;
                    wr_c      = 1'b1;
                    wdata_c   = {b0_hold, bus.Pix_R};
                    state_nxt = S_W2;
                end
            end
            S_W2: begin
                cnt_inc_c = 1'b1;
                wr_c      = 1'b1;
                wdata_c   = {g1_hold, b1_hold};
                state_nxt = (pix_cnt == LAST_PAIR_CNT) ? S_DONE : S_P0;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pixel counter, write address pointer and held pixel components
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pix_cnt <= '0;
            wr_addr <= '0;
            b0_hold <= '0;
            g1_hold <= '0;
            b1_hold <= '0;
        end else begin
            if (start_frame_c) begin
                pix_cnt <= '0;
                wr_addr <= RGB_BASE;
            end else begin
                if (cnt_inc_c) begin
                    pix_cnt <= pix_cnt + CNT_W'(2);
                end
                // Pointer past the last word is never presented on the bus
                if (wr_c) begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                end
            end
            if (take_p0_c) begin
                b0_hold <= bus.Pix_B;
            end
            if (take_p1_c) begin
                g1_hold <= bus.Pix_G;
                b1_hold <= bus.Pix_B;
            end
        end
    end

    // Registered SRAM write port and status outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            bus.Pix_ready       <= 1'b0;
            bus.SRAM_we_n       <= 1'b1;
            bus.SRAM_address    <= '0;
            bus.SRAM_write_data <= '0;
            Busy                <= 1'b0;
            Done                <= 1'b0;
        end else begin
            bus.Pix_ready <= (state_nxt == S_P0) || (state_nxt == S_P1);
            bus.SRAM_we_n <= ~wr_c;
            if (wr_c) begin
                bus.SRAM_address    <= wr_addr;
                bus.SRAM_write_data <= wdata_c;
            end
            Busy <= (state_nxt != S_IDLE);
            Done <= (state == S_DONE);
        end
    end

endmodule

// File: tb/tb_rgb_sram_packer.sv
// Randomized bench for rgb_sram_packer: a 4-pixel instance for directed
// framing/stall/reset scenarios and a 2000-pixel instance ending at the top
// of the address space, both checked against a pixel-pair word model.
module tb_rgb_sram_packer;

    localparam logic [17:0] BASE_A = 18'd146944;
    localparam int          NPIX_A = 4;
    localparam logic [17:0] BASE_B = 18'd259144;
    localparam int          NPIX_B = 2000;
    localparam int          WORDS_B = 3 * NPIX_B / 2;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_a, start_a, busy_a, done_a;
    logic rst_b, start_b, busy_b, done_b;

    rgb_sram_packer_if ifa ();
    rgb_sram_packer_if ifb ();

    rgb_sram_packer #(.RGB_BASE(BASE_A), .NUM_PIXELS(NPIX_A)) dut_a (
        .Clock(clk), .Reset(rst_a), .Start(start_a), .bus(ifa),
        .Busy(busy_a), .Done(done_a)
    );

    rgb_sram_packer #(.RGB_BASE(BASE_B), .NUM_PIXELS(NPIX_B)) dut_b (
        .Clock(clk), .Reset(rst_b), .Start(start_b), .bus(ifb),
        .Busy(busy_b), .Done(done_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word j (0..2) of the pair (p0, p1); each pixel is {R,G,B}
    function automatic logic [15:0] pair_word(input logic [23:0] p0, input logic [23:0] p1, input int j);
        case (j)
            0:       return {p0[23:16], p0[15:8]};
            1:       return {p0[7:0],   p1[23:16]};
            default: return {p1[15:8],  p1[7:0]};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A model and monitor ----------------
    logic [23:0] px_a [NPIX_A];
    logic [33:0] exp_q [$];
    logic [33:0] mon_e;
    int          done_cnt_a = 0;

    task automatic push_words_a(input int nwords);
        for (int k = 0; k < nwords; k++) begin
            exp_q.push_back({18'(BASE_A + 18'(k)), pair_word(px_a[(k/3)*2], px_a[(k/3)*2+1], k % 3)});
        end
    endtask

    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (ifa.SRAM_we_n === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("a_unexpected_write", 32'(ifa.SRAM_address), 32'h3ffff + 32'h1);
            end else begin
                mon_e = exp_q.pop_front();
                check("a_addr", 32'(ifa.SRAM_address), 32'(mon_e[33:16]));
                check("a_data", 32'(ifa.SRAM_write_data), 32'(mon_e[15:0]));
            end
        end
    end

    task automatic drive_pix_a(input logic v, input int idx);
        int ii;
        ii = (idx < NPIX_A) ? idx : 0;
        ifa.Pix_valid = v;
        ifa.Pix_R = px_a[ii][23:16];
        ifa.Pix_G = px_a[ii][15:8];
        ifa.Pix_B = px_a[ii][7:0];
    endtask

    // mode 0: fixed pixels, valid held; 1: fixed pixels, valid 1,0,0,1;
    // 2: random pixels, extra Start pulses while busy
    task automatic run_frame_a(input int mode, input int exp_cycles);
        int   idx;
        int   n;
        logic v;
        logic xf;
        idx = 0;
        n = 0;
        for (int i = 0; i < NPIX_A; i++) begin
            if (mode < 2) px_a[i] = {8'(3*i+1), 8'(3*i+2), 8'(3*i+3)};
            else          px_a[i] = 24'($urandom);
        end
        push_words_a(3 * NPIX_A / 2);
        done_cnt_a = 0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("a_busy_after_start", 32'(busy_a), 32'd1);
        while (n < 100 && done_a !== 1'b1) begin
            v = (idx < NPIX_A) && !(mode == 1 && (n == 1 || n == 2));
            drive_pix_a(v, idx);
            if (mode == 1 && (n == 1 || n == 2)) check("a_stall_ready", 32'(ifa.Pix_ready), 32'd1);
            start_a = (mode == 2) && (n == 2 || n == 4);
            xf = v && ifa.Pix_ready;
            step();
            n++;
            if (xf) idx++;
        end
        start_a = 1'b0;
        ifa.Pix_valid = 1'b0;
        check("a_done_seen", 32'(done_a), 32'd1);
        check("a_cycles_to_done", 32'(n), 32'(exp_cycles));
        check("a_busy_at_done", 32'(busy_a), 32'd0);
        check("a_pixels_taken", 32'(idx), 32'(NPIX_A));
        step();
        check("a_done_pulse_len", 32'(done_a), 32'd0);
        check("a_done_count", 32'(done_cnt_a), 32'd1);
        check("a_words_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs_a(input string tag);
        check({tag, "_ready"}, 32'(ifa.Pix_ready), 32'd0);
        check({tag, "_we_n"},  32'(ifa.SRAM_we_n), 32'd1);
        check({tag, "_addr"},  32'(ifa.SRAM_address), 32'd0);
        check({tag, "_data"},  32'(ifa.SRAM_write_data), 32'd0);
        check({tag, "_busy"},  32'(busy_a), 32'd0);
        check({tag, "_done"},  32'(done_a), 32'd0);
    endtask

    // ---------------- instance B model and monitor ----------------
    logic [23:0] px_b [NPIX_B];
    int          wr_b = 0;
    int          done_cnt_b = 0;
    logic [17:0] last_addr_b = '0;

    always @(negedge clk) begin
        if (done_b === 1'b1) done_cnt_b++;
        if (ifb.SRAM_we_n === 1'b0) begin
            if (wr_b >= WORDS_B) begin
                check("b_extra_write", 32'(wr_b), 32'(WORDS_B - 1));
            end else begin
                check("b_addr", 32'(ifb.SRAM_address), 32'(BASE_B) + 32'(wr_b));
                check("b_data", 32'(ifb.SRAM_write_data),
                      32'(pair_word(px_b[(wr_b/3)*2], px_b[(wr_b/3)*2+1], wr_b % 3)));
            end
            last_addr_b = ifb.SRAM_address;
            wr_b++;
        end
    end

    task automatic run_frame_b();
        int   idx;
        int   n;
        logic v;
        logic xf;
        idx = 0;
        n = 0;
        for (int i = 0; i < NPIX_B; i++) px_b[i] = 24'($urandom);
        rst_b = 1'b0;
        step();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        while (n < 20000 && done_b !== 1'b1) begin
            v = (idx < NPIX_B) && ($urandom_range(0, 3) != 0);
            ifb.Pix_valid = v;
            ifb.Pix_R = px_b[(idx < NPIX_B) ? idx : 0][23:16];
            ifb.Pix_G = px_b[(idx < NPIX_B) ? idx : 0][15:8];
            ifb.Pix_B = px_b[(idx < NPIX_B) ? idx : 0][7:0];
            xf = v && ifb.Pix_ready;
            step();
            n++;
            if (xf) idx++;
        end
        ifb.Pix_valid = 1'b0;
        check("b_done_seen", 32'(done_b), 32'd1);
        repeat (3) step();
        check("b_write_count", 32'(wr_b), 32'(WORDS_B));
        check("b_last_addr", 32'(last_addr_b), 32'd262143);
        check("b_done_count", 32'(done_cnt_b), 32'd1);
        check("b_busy_after", 32'(busy_b), 32'd0);
        check("b_pixels_taken", 32'(idx), 32'(NPIX_B));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   idx;
        logic xf;
        rst_a = 1'b1; start_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0;
        ifa.Pix_valid = 1'b0; ifa.Pix_R = '0; ifa.Pix_G = '0; ifa.Pix_B = '0;
        ifb.Pix_valid = 1'b0; ifb.Pix_R = '0; ifb.Pix_G = '0; ifb.Pix_B = '0;
        repeat (3) step();
        check_reset_outputs_a("a_rst");
        rst_a = 1'b0;

        // Pixels offered while idle must not be taken
        px_a[0] = 24'($urandom);
        drive_pix_a(1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("a_idle_ready", 32'(ifa.Pix_ready), 32'd0);
            check("a_idle_busy", 32'(busy_a), 32'd0);
        end
        ifa.Pix_valid = 1'b0;

        run_frame_a(0, 7);
        run_frame_a(1, 9);
        run_frame_a(2, 7);

        // Reset while the second pair waits in S_P1 (four words already out)
        for (int i = 0; i < NPIX_A; i++) px_a[i] = 24'($urandom);
        push_words_a(4);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        idx = 0;
        for (int n = 0; n < 4; n++) begin
            drive_pix_a(1'b1, idx);
            xf = ifa.Pix_ready;
            step();
            if (xf) idx++;
        end
        check("a_pre_reset_ready", 32'(ifa.Pix_ready), 32'd1);
        rst_a = 1'b1;
        step();
        ifa.Pix_valid = 1'b0;
        check_reset_outputs_a("a_midrst");
        rst_a = 1'b0;
        step();
        check("a_midrst_words_left", 32'(exp_q.size()), 32'd0);
        run_frame_a(2, 7);

        run_frame_b();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
